// File: rtl/fusion_pkg.sv
// fusion_pkg: shared types and sizing helpers for the signal fusion datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fusion_pkg;

    // Width of the saturating tie counter exposed as conflict_cnt.
    localparam int CONFLICT_W = 16;

    // Decision FSM: IDLE may emit, COOLDOWN suppresses everything.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COOLDOWN = 1'b1
    } fsm_state_t;

    // One channel's vote as carried through its alignment line.
    typedef struct packed {
        logic vld;
        logic buy;
        logic sell;
    } vote_t;

    // Score width holds DATA_CH full-scale weights without overflow.
    function automatic int score_w(int weight_w, int data_ch);
        return weight_w + $clog2(data_ch) + 1;
    endfunction

    // Delay selector width covers 0..MAX_DELAY.
    function automatic int dly_w(int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/vote_align_line.sv
// vote_align_line: per-channel shift register that re-times a vote by a programmable delay.
// Latency: 0..MAX_DELAY cycles as selected by delay (0 = live input, larger values clamp).
// Backpressure: none; shifts every cycle.
// Ports: in_vote live vote, delay selector, out_vote aligned vote.
module vote_align_line
    import fusion_pkg::*;
#(
    parameter int  MAX_DELAY = 4,
    localparam int DLY_W     = dly_w(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  vote_t            in_vote,
    input  logic [DLY_W-1:0] delay,
    output vote_t            out_vote
);

    // line_q[k] holds the vote from k+1 cycles ago.
    vote_t            line_q [MAX_DELAY];
    vote_t            line_d [MAX_DELAY];
    logic [DLY_W-1:0] dly_clamped;

    always_comb begin
        line_d[0] = in_vote;
        for (int k = 1; k < MAX_DELAY; k++) begin
            line_d[k] = line_q[k-1];
        end
    end

    // Tap select written as a compare chain so the selector width never has
    // to match the array index width.
    always_comb begin
        dly_clamped = (delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : delay;
        out_vote    = in_vote;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (dly_clamped == DLY_W'(k + 1)) begin
                out_vote = line_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (rst) begin
                line_q[k] <= '0;
            end else begin
                line_q[k] <= line_d[k];
            end
        end
    end

endmodule

// File: rtl/signal_fusion_unit.sv
// signal_fusion_unit: aligns per-channel strategy votes, sums weighted votes, emits buy/sell pulses.
// Latency: 2 cycles from the aligned sample to out_valid/buy_signal/sell_signal (scores after 1).
// Backpressure: none; one decision slot per cycle, a cooldown window suppresses pulses after each emission.
// Ports: enable, ch_valid/ch_buy/ch_sell votes and ch_delay alignment in; buy/sell weights, thresholds and
//        cooldown config in; buy_signal/sell_signal/out_valid pulses, busy, buy/sell_score, conflict_cnt out.
module signal_fusion_unit
    import fusion_pkg::*;
#(
    parameter int  DATA_CH   = 3,
    parameter int  MAX_DELAY = 4,
    parameter int  WEIGHT_W  = 3,
    parameter int  CD_W      = 8,
    localparam int SCORE_W   = score_w(WEIGHT_W, DATA_CH),
    localparam int DLY_W     = dly_w(MAX_DELAY)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [DATA_CH-1:0]               ch_valid,
    input  logic [DATA_CH-1:0]               ch_buy,
    input  logic [DATA_CH-1:0]               ch_sell,
    input  logic [DATA_CH-1:0][DLY_W-1:0]    ch_delay,
    input  logic [DATA_CH-1:0][WEIGHT_W-1:0] buy_weight,
    input  logic [DATA_CH-1:0][WEIGHT_W-1:0] sell_weight,
    input  logic [SCORE_W-1:0]               buy_thresh,
    input  logic [SCORE_W-1:0]               sell_thresh,
    input  logic [CD_W-1:0]                  cooldown,
    output logic                             buy_signal,
    output logic                             sell_signal,
    output logic                             out_valid,
    output logic                             busy,
    output logic [SCORE_W-1:0]               buy_score,
    output logic [SCORE_W-1:0]               sell_score,
    output logic [CONFLICT_W-1:0]            conflict_cnt
);

    vote_t in_vote [DATA_CH];
    vote_t al_vote [DATA_CH];

    // With enable low every channel shifts in an all-zero (invalid) vote.
    always_comb begin
        for (int i = 0; i < DATA_CH; i++) begin
            in_vote[i].vld  = enable & ch_valid[i];
            in_vote[i].buy  = enable & ch_buy[i];
            in_vote[i].sell = enable & ch_sell[i];
        end
    end

    for (genvar g = 0; g < DATA_CH; g++) begin : g_align
        vote_align_line #(
            .MAX_DELAY (MAX_DELAY)
        ) u_align (
            .clk      (clk),
            .rst      (rst),
            .in_vote  (in_vote[g]),
            .delay    (ch_delay[g]),
            .out_vote (al_vote[g])
        );
    end

    // Stage 1: fused valid and weighted scores.
    logic               s1_vld_d, s1_vld_q;
    logic [SCORE_W-1:0] buy_score_d, buy_score_q;
    logic [SCORE_W-1:0] sell_score_d, sell_score_q;

    always_comb begin
        s1_vld_d     = 1'b1;
        buy_score_d  = '0;
        sell_score_d = '0;
        for (int i = 0; i < DATA_CH; i++) begin
            s1_vld_d = s1_vld_d & al_vote[i].vld;
            if (al_vote[i].vld && al_vote[i].buy) begin
                buy_score_d = buy_score_d + SCORE_W'(buy_weight[i]);
            end
            if (al_vote[i].vld && al_vote[i].sell) begin
                sell_score_d = sell_score_d + SCORE_W'(sell_weight[i]);
            end
        end
    end

    // Stage 2: threshold, tie resolution, cooldown FSM.
    fsm_state_t          state_d, state_q;
    logic [CD_W-1:0]     cnt_d, cnt_q;
    logic [CONFLICT_W-1:0] conflict_d, conflict_q;
    logic                out_vld_d, out_vld_q;
    logic                buy_sig_d, buy_sig_q;
    logic                sell_sig_d, sell_sig_q;
    logic                buy_hit, sell_hit, tie, emit_buy, emit_sell;

    always_comb begin
        buy_hit   = s1_vld_q && (buy_score_q >= buy_thresh);
        sell_hit  = s1_vld_q && (sell_score_q >= sell_thresh);
        tie       = buy_hit && sell_hit && (buy_score_q == sell_score_q);
        // When both sides hit, only a strictly larger score wins.
        emit_buy  = buy_hit && (!sell_hit || (buy_score_q > sell_score_q));
        emit_sell = sell_hit && (!buy_hit || (sell_score_q > buy_score_q));

        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = conflict_q;
        out_vld_d  = s1_vld_q;
        buy_sig_d  = 1'b0;
        sell_sig_d = 1'b0;

        if (state_q == ST_IDLE) begin
            buy_sig_d  = emit_buy;
            sell_sig_d = emit_sell;
            if (tie && (conflict_q != '1)) begin
                conflict_d = conflict_q + CONFLICT_W'(1);
            end
            if ((emit_buy || emit_sell) && (cooldown != '0)) begin
                cnt_d   = cooldown;
                state_d = ST_COOLDOWN;
            end
        end else begin
            // The slot where the counter reads 1 is the last suppressed one.
            cnt_d = cnt_q - CD_W'(1);
            if (cnt_q == CD_W'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            buy_score_q  <= '0;
            sell_score_q <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            conflict_q   <= '0;
            out_vld_q    <= 1'b0;
            buy_sig_q    <= 1'b0;
            sell_sig_q   <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            buy_score_q  <= buy_score_d;
            sell_score_q <= sell_score_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            conflict_q   <= conflict_d;
            out_vld_q    <= out_vld_d;
            buy_sig_q    <= buy_sig_d;
            sell_sig_q   <= sell_sig_d;
        end
    end

    assign buy_signal   = buy_sig_q;
    assign sell_signal  = sell_sig_q;
    assign out_valid    = out_vld_q;
    assign busy         = (state_q == ST_COOLDOWN);
    assign buy_score    = buy_score_q;
    assign sell_score   = sell_score_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_signal_fusion_unit.sv
// tb_signal_fusion_unit: directed scenarios plus randomized traffic against a history-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_signal_fusion_unit;

    localparam int NCH  = 3;
    localparam int MAXD = 4;
    localparam int WW   = 3;
    localparam int CDW  = 8;
    localparam int SW   = 6;
    localparam int DW   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [NCH-1:0]         ch_valid, ch_buy, ch_sell;
    logic [NCH-1:0][DW-1:0] ch_delay;
    logic [NCH-1:0][WW-1:0] buy_weight, sell_weight;
    logic [SW-1:0]          buy_thresh, sell_thresh;
    logic [CDW-1:0]         cooldown;
    logic                   buy_signal, sell_signal, out_valid, busy;
    logic [SW-1:0]          buy_score, sell_score;
    logic [15:0]            conflict_cnt;

    always #5 clk = ~clk;

    signal_fusion_unit #(
        .DATA_CH   (NCH),
        .MAX_DELAY (MAXD),
        .WEIGHT_W  (WW),
        .CD_W      (CDW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ch_valid     (ch_valid),
        .ch_buy       (ch_buy),
        .ch_sell      (ch_sell),
        .ch_delay     (ch_delay),
        .buy_weight   (buy_weight),
        .sell_weight  (sell_weight),
        .buy_thresh   (buy_thresh),
        .sell_thresh  (sell_thresh),
        .cooldown     (cooldown),
        .buy_signal   (buy_signal),
        .sell_signal  (sell_signal),
        .out_valid    (out_valid),
        .busy         (busy),
        .buy_score    (buy_score),
        .sell_score   (sell_score),
        .conflict_cnt (conflict_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: past[c][a] is channel c's gated vote {v,b,s} from a cycles ago.
    logic [2:0] past [NCH][MAXD+1];
    bit         m_s1v, m_ov, m_buy, m_sell;
    int         m_bs, m_ss, m_cd, m_conf;

    task automatic model_edge();
        bit hb, hs, allv;
        int bsum, ssum, d;
        logic [2:0] smp;
        if (rst) begin
            foreach (past[c, a]) past[c][a] = 3'b000;
            m_s1v = 0; m_bs = 0; m_ss = 0;
            m_ov = 0; m_buy = 0; m_sell = 0; m_cd = 0; m_conf = 0;
        end else begin
            // Decision for the slot scored last cycle.
            hb = m_s1v && (m_bs >= int'(buy_thresh));
            hs = m_s1v && (m_ss >= int'(sell_thresh));
            m_ov = m_s1v; m_buy = 0; m_sell = 0;
            if (m_cd > 0) begin
                m_cd = m_cd - 1;
            end else begin
                if (hb && hs) begin
                    if (m_bs > m_ss) m_buy = 1;
                    else if (m_ss > m_bs) m_sell = 1;
                    else if (m_conf < 65535) m_conf = m_conf + 1;
                end else if (hb) begin
                    m_buy = 1;
                end else if (hs) begin
                    m_sell = 1;
                end
                if (m_buy || m_sell) m_cd = int'(cooldown);
            end
            // Record this cycle's input, then score the aligned samples.
            for (int c = 0; c < NCH; c++) begin
                for (int a = MAXD; a > 0; a--) past[c][a] = past[c][a-1];
                past[c][0] = enable ? {ch_valid[c], ch_buy[c], ch_sell[c]} : 3'b000;
            end
            allv = 1; bsum = 0; ssum = 0;
            for (int c = 0; c < NCH; c++) begin
                d = int'(ch_delay[c]);
                if (d > MAXD) d = MAXD;
                smp = past[c][d];
                if (!smp[2]) allv = 0;
                if (smp[2] && smp[1]) bsum += int'(buy_weight[c]);
                if (smp[2] && smp[0]) ssum += int'(sell_weight[c]);
            end
            m_s1v = allv; m_bs = bsum; m_ss = ssum;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] got();
        return {out_valid, buy_signal, sell_signal, busy, buy_score, sell_score, conflict_cnt};
    endfunction

    function automatic logic [31:0] want();
        return {m_ov, m_buy, m_sell, (m_cd > 0), SW'(m_bs), SW'(m_ss), 16'(m_conf)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [NCH-1:0][WW-1:0] bw, input logic [NCH-1:0][WW-1:0] sw,
                           input int bt, input int st, input int cd);
        buy_weight = bw; sell_weight = sw;
        buy_thresh = SW'(bt); sell_thresh = SW'(st); cooldown = CDW'(cd);
        ch_delay = '0; enable = 1'b1; ch_valid = '1; ch_buy = '0; ch_sell = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_vec++;
        if (got() !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", got(), 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_spec_example();
        do_reset();
        set_cfg({3'd2, 3'd1, 3'd4}, '0, 2, 63, 0);
        ch_delay = {3'd0, 3'd1, 3'd1};
        for (int k = 0; k < 4; k++) step();
        ch_buy = 3'b001;                           // cycle t
        step();
        ch_buy = 3'b100;                           // cycle t+1
        n_vec++;
        if (got() !== want()) begin n_bad++; $display("FAIL ex_t1: got %h want %h", got(), want()); end
        step();                                    // cycle t+2
        ch_buy = 3'b000;
        n_vec++;
        if (buy_score !== SW'(6)) begin n_bad++; $display("FAIL ex_score: got %0d want 6", buy_score); end
        n_vec++;
        if (buy_signal !== 1'b0) begin n_bad++; $display("FAIL ex_early: got %b want 0", buy_signal); end
        step();                                    // cycle t+3
        n_vec++;
        if ({out_valid, buy_signal, sell_signal} !== 3'b110) begin
            n_bad++; $display("FAIL ex_pulse: got %b want 110", {out_valid, buy_signal, sell_signal});
        end
        step();
        n_vec++;
        if (got() !== want()) begin n_bad++; $display("FAIL ex_after: got %h want %h", got(), want()); end
    endtask

    task automatic test_conflict();
        int  base;
        bit  any_pulse;
        do_reset();
        set_cfg({3'd0, 3'd1, 3'd2}, {3'd3, 3'd0, 3'd0}, 2, 2, 3);
        step();
        base = m_conf;
        any_pulse = 0;
        ch_buy = 3'b011; ch_sell = 3'b100;
        step();
        ch_buy = '0; ch_sell = '0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (got() !== want()) begin n_bad++; $display("FAIL tie_trace: got %h want %h", got(), want()); end
            any_pulse |= buy_signal | sell_signal;
            step();
        end
        n_vec++;
        if (conflict_cnt !== 16'(base + 1)) begin
            n_bad++; $display("FAIL tie_count: got %0d want %0d", conflict_cnt, base + 1);
        end
        n_vec++;
        if (any_pulse) begin n_bad++; $display("FAIL tie_pulse: got 1 want 0"); end
    endtask

    task automatic test_cooldown();
        int pulses[$];
        int busy_n = 0;
        do_reset();
        set_cfg({3'd1, 3'd1, 3'd1}, '0, 3, 63, 5);
        ch_buy = '1;
        for (int k = 0; k < 30; k++) begin
            step();
            n_vec++;
            if (got() !== want()) begin n_bad++; $display("FAIL cd_trace: got %h want %h", got(), want()); end
            if (buy_signal) pulses.push_back(k);
            if (busy && pulses.size() == 1) busy_n++;
        end
        n_vec++;
        if (pulses.size() < 3) begin
            n_bad++; $display("FAIL cd_pulses: got %0d want >=3", pulses.size());
        end else begin
            for (int i = 1; i < pulses.size(); i++) begin
                n_vec++;
                if (pulses[i] - pulses[i-1] !== 6) begin
                    n_bad++; $display("FAIL cd_spacing: got %0d want 6", pulses[i] - pulses[i-1]);
                end
            end
        end
        n_vec++;
        if (busy_n !== 5) begin n_bad++; $display("FAIL cd_busy_len: got %0d want 5", busy_n); end
    endtask

    task automatic test_reset_mid_cooldown();
        bit found = 0;
        do_reset();
        set_cfg({3'd1, 3'd1, 3'd1}, '0, 3, 63, 5);
        ch_buy = '1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (buy_signal) found = 1;
        end
        n_vec++;
        if (!found) begin
            n_bad++; $display("FAIL rmc_first: got no pulse want pulse within 20 cycles");
        end else begin
            step();
            step();
            n_vec++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL rmc_busy: got %b want 1", busy); end
            rst = 1'b1;
            step();
            n_vec++;
            if (got() !== 32'h0) begin n_bad++; $display("FAIL rmc_cleared: got %h want 0", got()); end
            rst = 1'b0;
            step();
            step();
            n_vec++;
            if ({buy_signal, busy} !== 2'b11) begin
                n_bad++; $display("FAIL rmc_next: got %b want 11", {buy_signal, busy});
            end
            n_vec++;
            if (got() !== want()) begin n_bad++; $display("FAIL rmc_model: got %h want %h", got(), want()); end
        end
    endtask

    task automatic test_valid_enable();
        do_reset();
        set_cfg({3'd1, 3'd1, 3'd1}, '0, 1, 63, 0);
        ch_buy = '1;
        ch_valid = 3'b101;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({out_valid, buy_signal, sell_signal} !== 3'b000) begin
                n_bad++; $display("FAIL inval: got %b want 000", {out_valid, buy_signal, sell_signal});
            end
            step();
        end
        ch_valid = '1;
        for (int k = 0; k < 3; k++) step();
        for (int k = 0; k < 7; k++) begin
            enable = (k < 3) ? 1'b0 : 1'b1;
            step();
            n_vec++;
            if (out_valid !== !(k >= 1 && k <= 3)) begin
                n_bad++; $display("FAIL enable_gap[%0d]: got %b want %b", k, out_valid, !(k >= 1 && k <= 3));
            end
            n_vec++;
            if (got() !== want()) begin n_bad++; $display("FAIL enable_model: got %h want %h", got(), want()); end
        end
    endtask

    task automatic test_random();
        int skip = 0;
        do_reset();
        set_cfg('0, '0, 2, 2, 0);
        for (int k = 0; k < 800; k++) begin
            if (k % 50 == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    buy_weight[c]  = WW'($urandom_range(0, 7));
                    sell_weight[c] = WW'($urandom_range(0, 7));
                end
                buy_thresh  = SW'($urandom_range(0, 14));
                sell_thresh = SW'($urandom_range(0, 14));
                cooldown    = CDW'($urandom_range(0, 6));
            end
            if (k % 100 == 0) begin
                for (int c = 0; c < NCH; c++) ch_delay[c] = DW'($urandom_range(0, 7));
                skip = MAXD + 2;
            end
            ch_buy   = NCH'($urandom());
            ch_sell  = NCH'($urandom());
            ch_valid = ($urandom_range(0, 4) == 0) ? NCH'($urandom()) : '1;
            enable   = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 199) == 0);
            step();
            if (skip > 0) begin
                skip--;
            end else begin
                n_vec++;
                if (got() !== want()) begin n_bad++; $display("FAIL rand[%0d]: got %h want %h", k, got(), want()); end
                n_vec++;
                if (buy_signal && sell_signal) begin n_bad++; $display("FAIL rand_both[%0d]: got 11 want not 11", k); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        set_cfg({3'd1, 3'd1, 3'd1}, {3'd1, 3'd1, 3'd1}, 1, 1, 0);
        ch_buy = '1; ch_sell = '1;
        for (int k = 0; k < 65542; k++) step();
        n_vec++;
        if (conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
        n_vec++;
        if (got() !== want()) begin n_bad++; $display("FAIL sat_model: got %h want %h", got(), want()); end
        for (int k = 0; k < 3; k++) step();
        n_vec++;
        if (conflict_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_wrap: got %h want ffff", conflict_cnt); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        ch_valid = '1; ch_buy = '0; ch_sell = '0; ch_delay = '0;
        buy_weight = '0; sell_weight = '0; buy_thresh = '1; sell_thresh = '1; cooldown = '0;
        test_reset();
        test_spec_example();
        test_conflict();
        test_cooldown();
        test_reset_mid_cooldown();
        test_valid_enable();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
